// File: rtl/limb_mul_pkg.sv
// Shared definitions for the sequential limb multiplier.
//   state_t    : controller states IDLE / MUL / DONE
//   idx_width  : bits needed to index n items, never less than 1
//   limb_lsb   : bit position of limb k in a packed vector of w-bit limbs
package limb_mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int limb_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/limb_mac.sv
// One schoolbook step: adds a single limb partial product, shifted into
// its limb position, onto the running accumulator. Purely combinational.
//   x, y    : W-bit limbs of A and B
//   s       : limb position of the partial product (i + j)
//   acc_in  : running 2N*W-bit accumulator
//   acc_out : acc_in + ((x * y) << (s * W))
module limb_mac #(
  parameter int W  = 16,
  parameter int N  = 2,
  parameter int SW = 2
) (
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic [SW-1:0]    s,
  input  logic [2*N*W-1:0] acc_in,
  output logic [2*N*W-1:0] acc_out
);

  localparam int P = 2 * N * W;

  logic [2*W-1:0] pp;
  logic [P-1:0]   pp_ext;

  always_comb begin
    pp      = x * y;
    pp_ext  = P'(pp);
    // The sum never exceeds the final product, so no carry out of P bits.
    acc_out = acc_in + (pp_ext << (s * W));
  end

endmodule

// File: rtl/limb_mul_seq.sv
// Sequential N-limb x N-limb unsigned multiplier with W-bit limbs.
// One W x W partial product is accumulated per cycle (N*N cycles), then the
// 2N-limb product is offered until the consumer takes it.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready high only when idle)
//   a, b                 : operands, limb k at [k*W +: W]
//   out_valid / out_ready: product handshake
//   y                    : product A*B, held while out_valid && !out_ready
//   busy                 : operation in flight or result awaiting pickup
module limb_mul_seq
  import limb_mul_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*W-1:0]   a,
  input  logic [N*W-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N*W-1:0] y,
  output logic             busy
);

  localparam int P  = 2 * N * W;
  localparam int IW = idx_width(N);
  // Index sum i+j reaches 2N-2, so size it for 2N positions.
  localparam int SW = idx_width(2 * N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t         state_reg, state_next;
  logic [IW-1:0]  i_reg, j_reg;
  logic [N*W-1:0] a_reg, b_reg;
  logic [P-1:0]   acc_reg, y_reg, acc_sum;
  logic [W-1:0]   a_limb [N];
  logic [W-1:0]   b_limb [N];
  logic           last_pp;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_limb
      assign a_limb[gi] = a_reg[limb_lsb(gi, W) +: W];
      assign b_limb[gi] = b_reg[limb_lsb(gi, W) +: W];
    end
  endgenerate

  limb_mac #(
    .W (W),
    .N (N),
    .SW(SW)
  ) u_mac (
    .x      (a_limb[i_reg]),
    .y      (b_limb[j_reg]),
    .s      (SW'(i_reg) + SW'(j_reg)),
    .acc_in (acc_reg),
    .acc_out(acc_sum)
  );

  assign last_pp   = (i_reg == LAST) && (j_reg == LAST);
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign y         = y_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = MUL;
      MUL:     if (last_pp) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
      y_reg   <= '0;
      i_reg   <= '0;
      j_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            acc_reg <= '0;
            i_reg   <= '0;
            j_reg   <= '0;
          end
        end
        MUL: begin
          acc_reg <= acc_sum;
          // j is the inner loop; i advances when j wraps.
          if (j_reg == LAST) begin
            j_reg <= '0;
            i_reg <= i_reg + IW'(1);
          end else begin
            j_reg <= j_reg + IW'(1);
          end
          // Capture the result only once complete so y never shows a
          // partial sum, and keeps its value after the handshake.
          if (last_pp) y_reg <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_limb_mul_seq.sv
// Bench for limb_mul_seq: three instances (N=2/W=16, N=4/W=8, N=1/W=16)
// checked against plain 64-bit multiplication of the operands.
module tb_limb_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        busy      [3];
  logic [31:0] a_d       [3];
  logic [31:0] b_d       [3];
  logic [63:0] y_n2, y_n4;
  logic [31:0] y_n1;

  int n_cmp = 0;
  int n_bad = 0;

  // limbs per operand and limb width of each instance
  int nl [3] = '{2, 4, 1};
  int wl [3] = '{16, 8, 16};

  limb_mul_seq #(.W(16), .N(2)) u_n2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_d[0]), .b(b_d[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .y(y_n2), .busy(busy[0])
  );

  limb_mul_seq #(.W(8), .N(4)) u_n4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_d[1]), .b(b_d[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .y(y_n4), .busy(busy[1])
  );

  limb_mul_seq #(.W(16), .N(1)) u_n1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_d[2][15:0]), .b(b_d[2][15:0]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .y(y_n1), .busy(busy[2])
  );

  function automatic logic [63:0] y_of(input int k);
    case (k)
      0:       return y_n2;
      1:       return y_n4;
      default: return {32'h0, y_n1};
    endcase
  endfunction

  function automatic logic [63:0] op_mask(input int k);
    return (64'h1 << (nl[k] * wl[k])) - 64'h1;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete operation on instance k. hold = cycles of backpressure
  // with random in_valid pulses before out_ready is raised.
  task automatic do_op(input int k, input logic [63:0] av_in, input logic [63:0] bv_in,
                       input int hold);
    logic [63:0] av, bv, exp;
    int lat;
    av  = av_in & op_mask(k);
    bv  = bv_in & op_mask(k);
    exp = av * bv;
    @(negedge clk);
    check($sformatf("idle_in_ready_%0d", k), 64'(in_ready[k]), 64'd1);
    a_d[k] = av[31:0];
    b_d[k] = bv[31:0];
    in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    // Operand bus changes after accept must not matter.
    a_d[k] = $urandom;
    b_d[k] = $urandom;
    lat = 0;
    while (!out_valid[k] && lat < 100) begin
      check($sformatf("mul_in_ready_%0d", k), 64'(in_ready[k]), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    // Edges counted after the accept edge until out_valid is seen high.
    check($sformatf("latency_%0d", k), 64'(lat), 64'(nl[k] * nl[k]));
    check($sformatf("y_%0d", k), y_of(k), exp);
    check($sformatf("done_busy_%0d", k), 64'(busy[k]), 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check($sformatf("bp_valid_%0d", k), 64'(out_valid[k]), 64'd1);
      check($sformatf("bp_y_%0d", k), y_of(k), exp);
      check($sformatf("bp_in_ready_%0d", k), 64'(in_ready[k]), 64'd0);
      in_valid[k] = 1'($urandom_range(0, 1));
      a_d[k] = $urandom;
      b_d[k] = $urandom;
    end
    @(negedge clk);
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    check($sformatf("post_valid_%0d", k), 64'(out_valid[k]), 64'd0);
    check($sformatf("post_in_ready_%0d", k), 64'(in_ready[k]), 64'd1);
    check($sformatf("post_y_%0d", k), y_of(k), exp);
    $display("op inst=%0d a=%h b=%h y=%h exp=%h lat=%0d", k, av, bv, y_of(k), exp, lat);
  endtask

  initial begin
    logic [63:0] ra, rb;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      a_d[k]       = '0;
      b_d[k]       = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_in_ready_%0d", k), 64'(in_ready[k]), 64'd1);
      check($sformatf("rst_out_valid_%0d", k), 64'(out_valid[k]), 64'd0);
      check($sformatf("rst_busy_%0d", k), 64'(busy[k]), 64'd0);
      check($sformatf("rst_y_%0d", k), y_of(k), 64'd0);
    end

    // Directed cases on the default geometry
    do_op(0, 64'h3, 64'h5, 0);
    do_op(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0);
    check("max_val", y_n2, 64'hFFFF_FFFE_0000_0001);
    do_op(0, 64'h0001_FFFF, 64'hFFFF_0001, 0);
    check("carry_val", y_n2, 64'h0001_FFFD_0002_FFFF);
    do_op(0, 64'h1234_5678, 64'h9ABC_DEF0, 10);

    // Reset two cycles after accept aborts the operation
    @(negedge clk);
    a_d[0] = 32'hDEAD_BEEF;
    b_d[0] = 32'h1234_5678;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", 64'(out_valid[0]), 64'd0);
    check("abort_in_ready", 64'(in_ready[0]), 64'd1);
    check("abort_busy", 64'(busy[0]), 64'd0);
    check("abort_y", y_n2, 64'd0);
    repeat (6) @(posedge clk);
    #1 check("abort_no_result", 64'(out_valid[0]), 64'd0);
    do_op(0, 64'd7, 64'd9, 0);
    check("after_abort_y", y_n2, 64'd63);

    // Random sweeps, including zero and all-ones operands
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 1000; t++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        if (t == 0) ra = '0;
        if (t == 1) rb = '0;
        if (t % 97 == 2) begin
          ra = '1;
          rb = '1;
        end
        do_op(k, ra, rb, (t % 200 == 5) ? 3 : 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
